dmux16_stream: RTL and testbench

- Demultiplexing counterpart of the 16-bit word selector: steers one incoming 16-bit word stream to one of two sink streams, a or b, chosen per word by sel.
- Each sink has its own small FIFO, so a stalled sink does not block words bound for the other sink once they are accepted.
- Placed between a single word producer (CPU write path, UART rx) and two independent consumers (e.g. RAM write port and Screen/IO write port).
- Also keeps a per-sink word counter for debug and test readback.

---
 rtl/dmux16_stream_pkg.sv | 22 ++
 rtl/dmux16_stream_word_fifo.sv | 69 ++++++
 rtl/dmux16_stream.sv | 85 ++++++++
 tb/tb_dmux16_stream.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/dmux16_stream_pkg.sv
// Shared constants and small helpers for the dmux16_stream word demultiplexer.
package dmux16_stream_pkg;

   // Default data word width and width of the per-sink debug counters.
   localparam int DEFAULT_WIDTH = 16;
   localparam int COUNT_WIDTH   = 16;

   // Number of sink streams; sel picks one of them per word.
   localparam int NUM_SINKS = 2;

   // Sink identifiers, matching the encoding of the sel input.
   typedef enum logic {
      SINK_A = 1'b0,
      SINK_B = 1'b1
   } sink_e;

   // Map the raw sel bit onto a sink identifier.
   function automatic sink_e sel_to_sink(input logic sel);
      return sel ? SINK_B : SINK_A;
   endfunction

endpackage

// File: rtl/dmux16_stream_word_fifo.sv
// Small synchronous FIFO holding words bound for one sink.
// Occupancy is tracked explicitly so full and empty never alias when the
// pointers wrap. The head word is read combinationally so a newly written
// word is visible one cycle after the write, and reads as 0 while empty.
module word_fifo #(
   parameter int WIDTH = 16,
   parameter int DEPTH = 2
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem_reg [DEPTH];
   logic [AW-1:0]    wr_ptr_reg;
   logic [AW-1:0]    rd_ptr_reg;
   logic [AW:0]      count_reg;
   logic [AW:0]      count_next;
   logic             push_ok;
   logic             pop_ok;

   assign full    = (count_reg == (AW+1)'(DEPTH));
   assign empty   = (count_reg == '0);
   assign push_ok = push && !full;
   assign pop_ok  = pop && !empty;
   assign head    = empty ? '0 : mem_reg[rd_ptr_reg];

   // Next occupancy: a simultaneous push and pop leaves it unchanged.
   always_comb begin
      count_next = count_reg;
      if (push_ok && !pop_ok) begin
         count_next = count_reg + 1'b1;
      end else if (pop_ok && !push_ok) begin
         count_next = count_reg - 1'b1;
      end
   end

   // Storage write; contents need no reset because head is gated by empty.
   always_ff @(posedge clk) begin
      if (push_ok) begin
         mem_reg[wr_ptr_reg] <= push_data;
      end
   end

   // Pointer and occupancy update; pointers wrap naturally since DEPTH is 2^AW.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_reg <= '0;
         rd_ptr_reg <= '0;
         count_reg  <= '0;
      end else begin
         if (push_ok) begin
            wr_ptr_reg <= wr_ptr_reg + 1'b1;
         end
         if (pop_ok) begin
            rd_ptr_reg <= rd_ptr_reg + 1'b1;
         end
         count_reg <= count_next;
      end
   end

endmodule

// File: rtl/dmux16_stream.sv
// Steers one incoming word stream to sink a or b chosen per word by sel.
// Each sink owns a FIFO so a stalled sink never blocks the other once a word
// is accepted. A per-sink counter records words accepted since reset.
module dmux16_stream
   import dmux16_stream_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int DEPTH = 2
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [WIDTH-1:0]       in,
   input  logic                   sel,
   input  logic                   in_valid,
   output logic                   in_ready,
   output logic [WIDTH-1:0]       a,
   output logic                   a_valid,
   input  logic                   a_ready,
   output logic [WIDTH-1:0]       b,
   output logic                   b_valid,
   input  logic                   b_ready,
   output logic [COUNT_WIDTH-1:0] a_count,
   output logic [COUNT_WIDTH-1:0] b_count
);

   logic [NUM_SINKS-1:0]   push;
   logic [NUM_SINKS-1:0]   pop;
   logic [NUM_SINKS-1:0]   full;
   logic [NUM_SINKS-1:0]   empty;
   logic [NUM_SINKS-1:0]   sink_ready;
   logic [WIDTH-1:0]       head  [NUM_SINKS];
   logic [COUNT_WIDTH-1:0] count [NUM_SINKS];
   sink_e                  target;
   logic                   accept;

   // Input side: ready reflects only the fullness of the selected sink.
   assign target     = sel_to_sink(sel);
   assign in_ready   = !full[target];
   assign accept     = in_valid && in_ready;
   assign sink_ready = {b_ready, a_ready};

   genvar gi;
   generate
      for (gi = 0; gi < NUM_SINKS; gi++) begin : g_sink
         logic [COUNT_WIDTH-1:0] count_reg;

         assign push[gi] = accept && (target == sink_e'(gi));
         // The FIFO ignores a pop while empty, so sink ready passes straight through.
         assign pop[gi]  = sink_ready[gi];

         word_fifo #(
            .WIDTH (WIDTH),
            .DEPTH (DEPTH)
         ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push[gi]),
            .push_data (in),
            .pop       (pop[gi]),
            .full      (full[gi]),
            .empty     (empty[gi]),
            .head      (head[gi])
         );

         // Free-running count of accepted words for this sink; wraps at 2^16.
         always_ff @(posedge clk) begin
            if (reset) begin
               count_reg <= '0;
            end else if (push[gi]) begin
               count_reg <= count_reg + 1'b1;
            end
         end

         assign count[gi] = count_reg;
      end
   endgenerate

   assign a       = head[SINK_A];
   assign a_valid = !empty[SINK_A];
   assign b       = head[SINK_B];
   assign b_valid = !empty[SINK_B];
   assign a_count = count[SINK_A];
   assign b_count = count[SINK_B];

endmodule

// File: tb/tb_dmux16_stream.sv
// Directed testbench for dmux16_stream with hand-computed expectations.
module tb_dmux16_stream;

   logic        clk = 1'b0;
   logic        reset;
   logic [15:0] in;
   logic        sel;
   logic        in_valid;
   logic        in_ready;
   logic [15:0] a;
   logic        a_valid;
   logic        a_ready;
   logic [15:0] b;
   logic        b_valid;
   logic        b_ready;
   logic [15:0] a_count;
   logic [15:0] b_count;

   int n_cmp = 0;
   int n_bad = 0;

   dmux16_stream #(.WIDTH(16), .DEPTH(2)) dut (
      .clk      (clk),
      .reset    (reset),
      .in       (in),
      .sel      (sel),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .a_valid  (a_valid),
      .a_ready  (a_ready),
      .b        (b),
      .b_valid  (b_valid),
      .b_ready  (b_ready),
      .a_count  (a_count),
      .b_count  (b_count)
   );

   always #5 clk = ~clk;

   // Advance one rising edge and settle 1 ns past it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; in_valid = 1'b1; in = 16'h1234; sel = 1'b0;
      a_ready = 1'b0; b_ready = 1'b0;
      tick();
      tick();
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL reset_a_valid: got %b want 0", a_valid); end
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL reset_b_valid: got %b want 0", b_valid); end
      n_cmp++; if (a !== 16'h0000) begin n_bad++; $display("FAIL reset_a: got %h want 0000", a); end
      n_cmp++; if (b !== 16'h0000) begin n_bad++; $display("FAIL reset_b: got %h want 0000", b); end
      n_cmp++; if (a_count !== 16'h0000) begin n_bad++; $display("FAIL reset_a_count: got %h want 0000", a_count); end
      n_cmp++; if (b_count !== 16'h0000) begin n_bad++; $display("FAIL reset_b_count: got %h want 0000", b_count); end
      reset = 1'b0; in_valid = 1'b0;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
      $display("test_reset: 1234 held during reset, not accepted");
   endtask

   task automatic test_basic_routing();
      a_ready = 1'b1; b_ready = 1'b1;
      in_valid = 1'b1; sel = 1'b0; in = 16'hAAAA;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL basic_in_ready: got %b want 1", in_ready); end
      tick();
      sel = 1'b1; in = 16'h5555;
      n_cmp++; if (a_valid !== 1'b1) begin n_bad++; $display("FAIL basic_a_valid: got %b want 1", a_valid); end
      n_cmp++; if (a !== 16'hAAAA) begin n_bad++; $display("FAIL basic_a: got %h want AAAA", a); end
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL basic_b_idle: got %b want 0", b_valid); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (b_valid !== 1'b1) begin n_bad++; $display("FAIL basic_b_valid: got %b want 1", b_valid); end
      n_cmp++; if (b !== 16'h5555) begin n_bad++; $display("FAIL basic_b: got %h want 5555", b); end
      n_cmp++; if (a_valid !== 1'b0 || a !== 16'h0000) begin n_bad++; $display("FAIL basic_a_drained: got valid=%b a=%h want 0/0000", a_valid, a); end
      n_cmp++; if (a_count !== 16'd1) begin n_bad++; $display("FAIL basic_a_count: got %0d want 1", a_count); end
      n_cmp++; if (b_count !== 16'd1) begin n_bad++; $display("FAIL basic_b_count: got %0d want 1", b_count); end
      tick();
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL basic_b_drained: got %b want 0", b_valid); end
      $display("test_basic_routing: AAAA->a, 5555->b");
   endtask

   task automatic test_backpressure();
      a_ready = 1'b0; b_ready = 1'b0;
      in_valid = 1'b1; sel = 1'b0; in = 16'h0001;
      tick();
      in = 16'h0002;
      tick();
      in = 16'h0009;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready_a_full: got %b want 0", in_ready); end
      sel = 1'b1; in = 16'h0003;
      #1;
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL bp_in_ready_b: got %b want 1", in_ready); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (b_valid !== 1'b1 || b !== 16'h0003) begin n_bad++; $display("FAIL bp_b_word: got valid=%b b=%h want 1/0003", b_valid, b); end
      n_cmp++; if (a !== 16'h0001) begin n_bad++; $display("FAIL bp_a_held: got %h want 0001", a); end
      b_ready = 1'b1;
      tick();
      n_cmp++; if (b_valid !== 1'b0) begin n_bad++; $display("FAIL bp_b_drained: got %b want 0", b_valid); end
      n_cmp++; if (a !== 16'h0001) begin n_bad++; $display("FAIL bp_a_stable: got %h want 0001", a); end
      a_ready = 1'b1;
      tick();
      n_cmp++; if (a_valid !== 1'b1 || a !== 16'h0002) begin n_bad++; $display("FAIL bp_a_second: got valid=%b a=%h want 1/0002", a_valid, a); end
      tick();
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL bp_a_empty: got %b want 0", a_valid); end
      n_cmp++; if (a_count !== 16'd3 || b_count !== 16'd2) begin n_bad++; $display("FAIL bp_counts: got a=%0d b=%0d want 3/2", a_count, b_count); end
      $display("test_backpressure: a drained 0001,0002 in order, b took 0003 while a stalled");
   endtask

   task automatic test_full_pop();
      a_ready = 1'b0; b_ready = 1'b1;
      in_valid = 1'b1; sel = 1'b0; in = 16'h0020;
      tick();
      in = 16'h0021;
      tick();
      a_ready = 1'b1; in = 16'h00FF;
      #1;
      n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL fp_in_ready_full: got %b want 0", in_ready); end
      tick();
      n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL fp_in_ready_after_pop: got %b want 1", in_ready); end
      n_cmp++; if (a !== 16'h0021) begin n_bad++; $display("FAIL fp_a_head: got %h want 0021", a); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (a_valid !== 1'b1 || a !== 16'h00FF) begin n_bad++; $display("FAIL fp_a_ff: got valid=%b a=%h want 1/00FF", a_valid, a); end
      tick();
      n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL fp_a_empty: got %b want 0", a_valid); end
      n_cmp++; if (a_count !== 16'd6) begin n_bad++; $display("FAIL fp_a_count: got %0d want 6", a_count); end
      $display("test_full_pop: 00FF refused while full, accepted next cycle");
   endtask

   task automatic test_wrap();
      int pushed = 0;
      int popped = 0;
      int occ = 0;
      int c = 0;
      logic want_push;
      logic do_push;
      logic do_pop;
      b_ready = 1'b0; sel = 1'b0;
      while (popped < 7 && c < 60) begin
         want_push = (c % 3) != 2;
         in_valid  = want_push && (pushed < 7);
         in        = 16'h0010 + 16'(pushed);
         a_ready   = (c % 4) != 0;
         #1;
         n_cmp++; if (in_ready !== (occ < 2)) begin n_bad++; $display("FAIL wrap_in_ready c=%0d: got %b want %b", c, in_ready, (occ < 2)); end
         if (occ > 0) begin
            n_cmp++; if (a_valid !== 1'b1 || a !== 16'h0010 + 16'(popped)) begin n_bad++; $display("FAIL wrap_head c=%0d: got valid=%b a=%h want 1/%h", c, a_valid, a, 16'h0010 + 16'(popped)); end
         end else begin
            n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL wrap_empty c=%0d: got %b want 0", c, a_valid); end
         end
         do_push = in_valid && (occ < 2);
         do_pop  = a_ready && (occ > 0);
         if (do_pop) $display("wrap: pop %h", a);
         tick();
         if (do_push) begin pushed++; occ++; end
         if (do_pop) begin popped++; occ--; end
         c++;
      end
      in_valid = 1'b0;
      n_cmp++; if (popped != 7) begin n_bad++; $display("FAIL wrap_done: got %0d popped want 7", popped); end
   endtask

   task automatic test_counter_wrap();
      reset = 1'b1; in_valid = 1'b0;
      tick();
      reset = 1'b0;
      b_ready = 1'b1; a_ready = 1'b0;
      sel = 1'b1; in = 16'hBEEF; in_valid = 1'b1;
      for (int i = 0; i < 65535; i++) tick();
      n_cmp++; if (b_count !== 16'hFFFF) begin n_bad++; $display("FAIL cw_b_count_max: got %h want FFFF", b_count); end
      tick();
      in_valid = 1'b0;
      n_cmp++; if (b_count !== 16'h0000) begin n_bad++; $display("FAIL cw_b_count_wrap: got %h want 0000", b_count); end
      n_cmp++; if (a_count !== 16'h0000) begin n_bad++; $display("FAIL cw_a_count: got %h want 0000", a_count); end
      tick();
      $display("test_counter_wrap: 65536 words accepted to b");
   endtask

   task automatic test_reset_mid();
      a_ready = 1'b0; sel = 1'b0; in_valid = 1'b1; in = 16'h0101;
      tick();
      in = 16'h0102;
      tick();
      in_valid = 1'b0;
      n_cmp++; if (a_valid !== 1'b1 || a !== 16'h0101) begin n_bad++; $display("FAIL rm_queued: got valid=%b a=%h want 1/0101", a_valid, a); end
      reset = 1'b1;
      tick();
      reset = 1'b0; a_ready = 1'b1;
      n_cmp++; if (a_valid !== 1'b0 || a !== 16'h0000) begin n_bad++; $display("FAIL rm_flushed: got valid=%b a=%h want 0/0000", a_valid, a); end
      n_cmp++; if (a_count !== 16'h0000) begin n_bad++; $display("FAIL rm_a_count: got %h want 0000", a_count); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_cmp++; if (a_valid !== 1'b0) begin n_bad++; $display("FAIL rm_stays_empty %0d: got %b want 0", i, a_valid); end
      end
      $display("test_reset_mid: queued 0101,0102 discarded");
   endtask

   initial begin
      test_reset();
      test_basic_routing();
      test_backpressure();
      test_full_pop();
      test_wrap();
      test_counter_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
